// File: rtl/ifmap_row_framer.sv
// ---------------------------------------------------------------------------
// ifmap_row_framer
//
// Upstream feeder for the CNN IFmap buffer. Takes raw activations from a
// valid/ready source, groups them into rows of a programmed length and tags
// each word with start-of-row / end-of-row flags in the two MSBs. A frame
// can optionally end with a zero-data flush row (length = filter size) that
// pushes the last partial sum out of the downstream array.
//
// Ports
//   clk                        : rising-edge clock
//   reset                      : asynchronous, active-low reset
//   start                      : one-cycle pulse, latches config, begins frame
//   row_len / num_rows         : words per row / rows per frame (at start)
//   flush_en / flush_len       : append a flush row of flush_len words
//   src_data/src_valid/src_ready : activation input stream
//   IFmap_buffer_in            : {sor, eor, data}
//   IFmap_buffer_write_enable  : output word valid
//   IFmap_buffer_ready         : IFmap buffer accepts this cycle
//   busy                       : frame in progress
//   done                       : one-cycle pulse after the final word leaves
// ---------------------------------------------------------------------------
module ifmap_row_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  num_rows,
  input  logic                  flush_en,
  input  logic [LEN_WIDTH-1:0]  flush_len,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH+1:0] IFmap_buffer_in,
  output logic                  IFmap_buffer_write_enable,
  input  logic                  IFmap_buffer_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DRAIN
  } state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                state, state_nxt;

  logic [LEN_WIDTH-1:0]  row_len_q,   row_len_nxt;
  logic [LEN_WIDTH-1:0]  num_rows_q,  num_rows_nxt;
  logic                  flush_en_q,  flush_en_nxt;
  logic [LEN_WIDTH-1:0]  flush_len_q, flush_len_nxt;
  logic [LEN_WIDTH-1:0]  col_cnt,     col_cnt_nxt;
  logic [LEN_WIDTH-1:0]  row_cnt,     row_cnt_nxt;

  logic [DATA_WIDTH+1:0] out_data,    out_data_nxt;
  logic                  out_vld,     out_vld_nxt;
  logic                  done_q,      done_nxt;
  logic                  src_ready_c;

  // The single output slot can take a new word when it is empty or its
  // current word leaves on this same edge (no bubble on back-to-back loads).
  logic out_free;
  assign out_free = !out_vld || IFmap_buffer_ready;

  logic row_col_last;
  logic row_last;
  logic flush_col_last;
  assign row_col_last   = (col_cnt == row_len_q - ONE);
  assign row_last       = (row_cnt == num_rows_q - ONE);
  assign flush_col_last = (col_cnt == flush_len_q - ONE);

  // -------------------------------------------------------------------------
  // Next-state and datapath-next logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt     = state;
    row_len_nxt   = row_len_q;
    num_rows_nxt  = num_rows_q;
    flush_en_nxt  = flush_en_q;
    flush_len_nxt = flush_len_q;
    col_cnt_nxt   = col_cnt;
    row_cnt_nxt   = row_cnt;
    out_data_nxt  = out_data;
    out_vld_nxt   = out_vld && !IFmap_buffer_ready;
    done_nxt      = 1'b0;
    src_ready_c   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (row_len != '0 && num_rows != '0) begin
            row_len_nxt   = row_len;
            num_rows_nxt  = num_rows;
            flush_en_nxt  = flush_en;
            flush_len_nxt = flush_len;
            col_cnt_nxt   = '0;
            row_cnt_nxt   = '0;
            state_nxt     = S_STREAM;
          end else begin
            // Empty frame: nothing to send, just acknowledge.
            done_nxt = 1'b1;
          end
        end
      end

      S_STREAM: begin
        src_ready_c = out_free;
        if (src_valid && out_free) begin
          out_data_nxt = {(col_cnt == '0), row_col_last, src_data};
          out_vld_nxt  = 1'b1;
          if (row_col_last) begin
            col_cnt_nxt = '0;
            row_cnt_nxt = row_cnt + ONE;
            if (row_last) begin
              state_nxt = (flush_en_q && flush_len_q != '0) ? S_FLUSH : S_DRAIN;
            end
          end else begin
            col_cnt_nxt = col_cnt + ONE;
          end
        end
      end

      S_FLUSH: begin
        if (out_free) begin
          out_data_nxt = {(col_cnt == '0), flush_col_last, {DATA_WIDTH{1'b0}}};
          out_vld_nxt  = 1'b1;
          if (flush_col_last) begin
            col_cnt_nxt = '0;
            state_nxt   = S_DRAIN;
          end else begin
            col_cnt_nxt = col_cnt + ONE;
          end
        end
      end

      S_DRAIN: begin
        // The last word is in the slot; done goes out once it has left.
        if (out_free) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= S_IDLE;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      flush_en_q  <= 1'b0;
      flush_len_q <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      out_data    <= '0;
      out_vld     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      row_len_q   <= row_len_nxt;
      num_rows_q  <= num_rows_nxt;
      flush_en_q  <= flush_en_nxt;
      flush_len_q <= flush_len_nxt;
      col_cnt     <= col_cnt_nxt;
      row_cnt     <= row_cnt_nxt;
      out_data    <= out_data_nxt;
      out_vld     <= out_vld_nxt;
      done_q      <= done_nxt;
    end
  end

  assign src_ready                 = src_ready_c;
  assign IFmap_buffer_in           = out_data;
  assign IFmap_buffer_write_enable = out_vld;
  assign busy                      = (state != S_IDLE);
  assign done                      = done_q;

endmodule

// File: tb/tb_ifmap_row_framer.sv
// ---------------------------------------------------------------------------
// tb_ifmap_row_framer
//
// Directed self-checking bench for ifmap_row_framer: basic frame, flush row,
// backpressure with a random source, single-word rows, degenerate and
// ignored starts, and an asynchronous reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_ifmap_row_framer;

  localparam int DW = 16;
  localparam int LW = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic [LW-1:0] row_len;
  logic [LW-1:0] num_rows;
  logic          flush_en;
  logic [LW-1:0] flush_len;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic [DW+1:0] ifm_in;
  logic          ifm_we;
  logic          ifm_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_q[$];
  logic [DW+1:0] exp_q[$];

  ifmap_row_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .row_len                   (row_len),
    .num_rows                  (num_rows),
    .flush_en                  (flush_en),
    .flush_len                 (flush_len),
    .src_data                  (src_data),
    .src_valid                 (src_valid),
    .src_ready                 (src_ready),
    .IFmap_buffer_in           (ifm_in),
    .IFmap_buffer_write_enable (ifm_we),
    .IFmap_buffer_ready        (ifm_ready),
    .busy                      (busy),
    .done                      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at posedge+1. Pulses start with the given config, then scrambles
  // the config inputs, which must be ignored from here on.
  task automatic do_start(input logic [LW-1:0] rl, input logic [LW-1:0] nr,
                          input logic fe, input logic [LW-1:0] fl);
    start     = 1'b1;
    row_len   = rl;
    num_rows  = nr;
    flush_en  = fe;
    flush_len = fl;
    @(posedge clk); #1;
    start     = 1'b0;
    row_len   = LW'($urandom_range(0, 31));
    num_rows  = LW'($urandom_range(0, 31));
    flush_en  = 1'b0;
    flush_len = LW'($urandom_range(0, 31));
  endtask

  task automatic degen_start(input string tag, input logic [LW-1:0] rl,
                             input logic [LW-1:0] nr);
    do_start(rl, nr, 1'b0, 5'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_we"},   32'(ifm_we), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_we_after"}, 32'(ifm_we), 32'd0);
  endtask

  // Streams src_q through the DUT and compares the output against exp_q.
  // Entered at posedge+1 of the cycle after start.
  task automatic run_frame(input string tag, input bit bp, input bit rnd_valid,
                           input int poke_cyc, output int first_cyc,
                           output int last_cyc);
    int            si = 0;
    int            ri = 0;
    int            cyc = 0;
    bit            hold_chk = 1'b0;
    bit            done_seen = 1'b0;
    logic [DW+1:0] held = '0;
    first_cyc = -1;
    last_cyc  = -1;
    while (!done_seen && cyc < 300) begin
      src_valid = (si < src_q.size()) && (rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1);
      src_data  = (si < src_q.size()) ? src_q[si] : '0;
      ifm_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (cyc == poke_cyc) begin
        start    = 1'b1;
        row_len  = 5'd2;
        num_rows = 5'd1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (hold_chk) begin
        check({tag, "_hold_we"},   32'(ifm_we), 32'd1);
        check({tag, "_hold_data"}, 32'(ifm_in), 32'(held));
      end
      if (si >= src_q.size())
        check({tag, "_src_ready_low"}, 32'(src_ready), 32'd0);
      if (src_valid && src_ready) si++;
      if (ifm_we && ifm_ready) begin
        if (ri < exp_q.size()) begin
          check($sformatf("%s_word%0d", tag, ri), 32'(ifm_in), 32'(exp_q[ri]));
        end else begin
          check({tag, "_extra_word"}, 32'(ri), 32'(exp_q.size()));
        end
        if (ri == 0) first_cyc = cyc;
        ri++;
        if (ri == exp_q.size()) last_cyc = cyc;
      end
      hold_chk = ifm_we && !ifm_ready;
      held     = ifm_in;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (ri >= exp_q.size()) begin
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        done_seen = 1'b1;
      end else begin
        check({tag, "_done_early"}, 32'(done), 32'd0);
      end
    end
    if (!done_seen) check({tag, "_timeout"}, 32'(ri), 32'(exp_q.size()));
    src_valid = 1'b0;
    ifm_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_we_idle"}, 32'(ifm_we), 32'd0);
  endtask

  task automatic load_basic();
    src_q.delete();
    exp_q.delete();
    for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
    exp_q = '{18'h20001, 18'h00002, 18'h00003, 18'h10004,
              18'h20005, 18'h00006, 18'h00007, 18'h10008};
  endtask

  initial begin
    int first_cyc;
    int last_cyc;
    int n_xfer;
    int si;

    reset     = 1'b0;
    start     = 1'b0;
    row_len   = '0;
    num_rows  = '0;
    flush_en  = 1'b0;
    flush_len = '0;
    src_data  = '0;
    src_valid = 1'b0;
    ifm_ready = 1'b1;

    // Reset state
    #3;
    check("rst_in",        32'(ifm_in),    32'd0);
    check("rst_we",        32'(ifm_we),    32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Basic frame, with a start pulse mid-frame that must be ignored
    load_basic();
    do_start(5'd4, 5'd2, 1'b0, 5'd0);
    check("basic_busy",      32'(busy), 32'd1);
    check("basic_src_ready", 32'(src_ready), 32'd1);
    run_frame("basic", 1'b0, 1'b0, 3, first_cyc, last_cyc);
    check("basic_first_xfer", 32'(first_cyc), 32'd1);
    check("basic_last_xfer",  32'(last_cyc),  32'd8);

    // Flush row
    src_q.delete();
    exp_q.delete();
    src_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    exp_q = '{18'h20011, 18'h00022, 18'h00033, 18'h10044,
              18'h20000, 18'h00000, 18'h00000, 18'h10000};
    do_start(5'd4, 5'd1, 1'b1, 5'd4);
    run_frame("flush", 1'b0, 1'b0, -1, first_cyc, last_cyc);
    check("flush_last_xfer", 32'(last_cyc), 32'd8);

    // Backpressure with a random source
    load_basic();
    do_start(5'd4, 5'd2, 1'b0, 5'd0);
    run_frame("bp", 1'b1, 1'b1, -1, first_cyc, last_cyc);

    // Single-word rows
    src_q.delete();
    exp_q.delete();
    src_q = '{16'h000A, 16'h000B, 16'h000C};
    exp_q = '{18'h3000A, 18'h3000B, 18'h3000C};
    do_start(5'd1, 5'd3, 1'b0, 5'd0);
    run_frame("single", 1'b0, 1'b0, -1, first_cyc, last_cyc);

    // Degenerate starts
    degen_start("zero_rows", 5'd4, 5'd0);
    degen_start("zero_len",  5'd0, 5'd2);

    // Reset mid-frame after three words
    load_basic();
    do_start(5'd4, 5'd2, 1'b0, 5'd0);
    n_xfer = 0;
    si     = 0;
    for (int c = 0; c < 20 && n_xfer < 3; c++) begin
      src_valid = 1'b1;
      src_data  = src_q[si];
      ifm_ready = 1'b1;
      #1;
      if (src_ready) si++;
      if (ifm_we) n_xfer++;
      @(posedge clk); #1;
    end
    check("rst_mid_reached", 32'(n_xfer), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_in",        32'(ifm_in),    32'd0);
    check("rst_mid_we",        32'(ifm_we),    32'd0);
    check("rst_mid_src_ready", 32'(src_ready), 32'd0);
    check("rst_mid_busy",      32'(busy),      32'd0);
    check("rst_mid_done",      32'(done),      32'd0);
    src_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    load_basic();
    do_start(5'd4, 5'd2, 1'b0, 5'd0);
    run_frame("post_rst", 1'b0, 1'b0, -1, first_cyc, last_cyc);
    check("post_rst_first_xfer", 32'(first_cyc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
